// File: rtl/wb_timeout_bridge.sv
// wb_timeout_bridge: single-outstanding Wishbone pipelined bridge in front of a register block.
// Accepts one upstream request, presents it downstream (holding through stall), and returns
// exactly one upstream response. Define WB_BRIDGE_TIMEOUT_EN to add a watchdog that ends
// unacknowledged transactions with a bus error after TIMEOUT cycles in REQ+WAIT.
module wb_timeout_bridge #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // Upstream (interconnect) side
    input  logic                  s_cyc_i,
    input  logic                  s_stb_i,
    input  logic                  s_we_i,
    input  logic [3:0]            s_sel_i,
    input  logic [ADDR_WIDTH-1:0] s_adr_i,
    input  logic [31:0]           s_dat_i,
    output logic                  s_ack_o,
    output logic                  s_err_o,
    output logic                  s_rty_o,
    output logic                  s_stall_o,
    output logic [31:0]           s_dat_o,
    // Downstream (register block) side
    output logic                  m_cyc_o,
    output logic                  m_stb_o,
    output logic                  m_we_o,
    output logic [3:0]            m_sel_o,
    output logic [ADDR_WIDTH-1:0] m_adr_o,
    output logic [31:0]           m_dat_o,
    input  logic                  m_ack_i,
    input  logic                  m_err_i,
    input  logic                  m_rty_i,
    input  logic                  m_stall_i,
    input  logic [31:0]           m_dat_i,
    // Status
    output logic                  busy_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_we;
    logic [3:0]              r_sel;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [31:0]             r_wdat;
    logic [31:0]             r_rdat;
    logic                    r_ack;
    logic                    r_err;
    logic                    r_rty;
    logic                    w_accept;
    logic                    w_active;
    logic                    w_rsp_any;
    logic                    w_take_rsp;
    logic                    w_expire;
    logic                    w_fire;

    assign w_active  = (r_state == StReq) || (r_state == StWait);
    assign w_rsp_any = m_ack_i | m_err_i | m_rty_i;

    // Next-state decode; abort beats response, response beats watchdog expiry.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_take_rsp   = 1'b0;
        w_fire       = 1'b0;
        case (r_state)
            StIdle: begin
                if (s_cyc_i && s_stb_i) begin
                    w_accept     = 1'b1;
                    w_state_next = StReq;
                end
            end
            StReq: begin
                if (!s_cyc_i) begin
                    w_state_next = StIdle;
                end else if (!m_stall_i && w_rsp_any) begin
                    w_take_rsp   = 1'b1;
                    w_state_next = StResp;
                end else if (w_expire) begin
                    w_fire       = 1'b1;
                    w_state_next = StResp;
                end else if (!m_stall_i) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (!s_cyc_i) begin
                    w_state_next = StIdle;
                end else if (w_rsp_any) begin
                    w_take_rsp   = 1'b1;
                    w_state_next = StResp;
                end else if (w_expire) begin
                    w_fire       = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request fields are captured on accept and held until the next accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we   <= 1'b0;
            r_sel  <= '0;
            r_adr  <= '0;
            r_wdat <= '0;
        end else if (w_accept) begin
            r_we   <= s_we_i;
            r_sel  <= s_sel_i;
            r_adr  <= s_adr_i;
            r_wdat <= s_dat_i;
        end
    end

    // Response kind and data; err > rty > ack when several arrive together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_rty  <= 1'b0;
            r_rdat <= '0;
        end else if (w_take_rsp) begin
            r_err  <= m_err_i;
            r_rty  <= !m_err_i && m_rty_i;
            r_ack  <= !m_err_i && !m_rty_i && m_ack_i;
            r_rdat <= m_dat_i;
        end else if (w_fire) begin
            r_err  <= 1'b1;
            r_rty  <= 1'b0;
            r_ack  <= 1'b0;
            r_rdat <= '0;
        end
    end

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

    logic [CntW-1:0] r_cnt;
    logic            r_tmo;

    // Watchdog counter: cleared on accept, counts REQ+WAIT cycles, saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_active && (r_cnt != CntMax)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is flagged on the edge where the counter would reach TIMEOUT.
    assign w_expire = w_active && (r_cnt == CntLast);

    // Remembers that the pending response came from the watchdog.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo <= 1'b0;
        end else if (w_take_rsp) begin
            r_tmo <= 1'b0;
        end else if (w_fire) begin
            r_tmo <= 1'b1;
        end
    end

    assign timeout_o = (r_state == StResp) && r_tmo;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("wb_timeout_bridge: TIMEOUT must be in 1..65535");
    end

    assign m_cyc_o   = w_active;
    assign m_stb_o   = (r_state == StReq);
    assign m_we_o    = r_we;
    assign m_sel_o   = r_sel;
    assign m_adr_o   = r_adr;
    assign m_dat_o   = r_wdat;
    assign s_stall_o = (r_state != StIdle);
    assign busy_o    = (r_state != StIdle);
    assign s_ack_o   = (r_state == StResp) && r_ack;
    assign s_err_o   = (r_state == StResp) && r_err;
    assign s_rty_o   = (r_state == StResp) && r_rty;
    assign s_dat_o   = r_rdat;

endmodule
